// File: rtl/cordic_angle_accum_pkg.sv
// Shared constants for the angle accumulator: arctangent table, quadrant codes,
// and a helper that rescales the 16-bit table to other angle widths.
package cordic_pkg;

    localparam int ATAN_LEN   = 16;
    localparam int ATAN_REF_W = 16;

    // round(atan(2^-k) / (2*pi) * 2^16)
    localparam logic [15:0] ATAN16 [ATAN_LEN] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    typedef enum logic [1:0] {
        QUAD_I   = 2'd0,
        QUAD_II  = 2'd1,
        QUAD_III = 2'd2,
        QUAD_IV  = 2'd3
    } quad_e;

    // Each quadrant step is a quarter turn: quad * 2^(ANG_W-2).
    localparam int QUAD_SHIFT_FROM_MSB = 2;

    function automatic logic [31:0] atan_scaled(input int k, input int ang_w);
        logic [31:0] base;
        if (k < 0 || k >= ATAN_LEN) begin
            return 32'd0;
        end
        base = {16'd0, ATAN16[k]};
        if (ang_w >= ATAN_REF_W) begin
            return base << (ang_w - ATAN_REF_W);
        end
        return (base + (32'd1 << (ATAN_REF_W - ang_w - 1))) >> (ATAN_REF_W - ang_w);
    endfunction

endpackage

// File: rtl/cordic_angle_accum_if.sv
// Sample/flag input and angle output bundle for cordic_angle_accum.
// quad_in exists only when CORDIC_QUAD_EN is defined.
interface cordic_angle_accum_if #(
    parameter int NSTAGE = 8,
    parameter int ANG_W  = 16
);
    // Valid-only protocol: in_valid marks one sample per cycle and out_valid is a
    // one-cycle strobe per result; there is no ready, the pipe never stalls.
    logic              in_valid;
    logic [NSTAGE-1:0] cmp_bits;
`ifdef CORDIC_QUAD_EN
    logic [1:0]        quad_in;
`endif
    logic              out_valid;
    logic [ANG_W-1:0]  out_angle;

`ifdef CORDIC_QUAD_EN
    modport master (output in_valid, cmp_bits, quad_in, input out_valid, out_angle);
    modport slave  (input in_valid, cmp_bits, quad_in, output out_valid, out_angle);
`else
    modport master (output in_valid, cmp_bits, input out_valid, out_angle);
    modport slave  (input in_valid, cmp_bits, output out_valid, out_angle);
`endif

endinterface

// File: rtl/cordic_angle_accum_slot.sv
// One accumulator stage: valid bit, partial angle sum and (with CORDIC_QUAD_EN)
// the quadrant code travelling alongside the sample.
module cordic_acc_slot #(
    parameter int               ANG_W  = 16,
    parameter logic [ANG_W-1:0] ATAN_K = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_i,
    input  logic [ANG_W-1:0] acc_i,
    input  logic             cmp_i,
`ifdef CORDIC_QUAD_EN
    input  logic [1:0]       quad_i,
    output logic [1:0]       quad_o,
`endif
    output logic             vld_o,
    output logic [ANG_W-1:0] acc_o
);

    logic             vld_d, vld_q;
    logic [ANG_W-1:0] acc_d, acc_q;

    always_comb begin
        vld_d = vld_i;
        acc_d = acc_i + (cmp_i ? ATAN_K : '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= 1'b0;
            acc_q <= '0;
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
        end
    end

    assign vld_o = vld_q;
    assign acc_o = acc_q;

`ifdef CORDIC_QUAD_EN
    logic [1:0] quad_d, quad_q;

    always_comb begin
        quad_d = quad_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            quad_q <= 2'd0;
        end else begin
            quad_q <= quad_d;
        end
    end

    assign quad_o = quad_q;
`endif

endmodule

// File: rtl/cordic_angle_accum.sv
// Re-aligns the skewed per-stage compare flags of the XY CORDIC and sums the
// arctangents of rotated stages into one binary angle per sample. Macro CORDIC_QUAD_EN adds quadrant offset.
module cordic_angle_accum
    import cordic_pkg::*;
#(
    parameter int NSTAGE = 8,
    parameter int ANG_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    cordic_angle_accum_if.slave   bus
);

    if (NSTAGE > ATAN_LEN) begin : g_bad_nstage
        $error("cordic_angle_accum: NSTAGE exceeds ATAN table length");
    end

    // Stage k's flag arrives one cycle after its input edge, so the valid bit is
    // registered once before slot 0 to line it up with cmp_bits[0].
    logic launch_vld_d, launch_vld_q;

    logic             vld_c [NSTAGE+1];
    logic [ANG_W-1:0] acc_c [NSTAGE+1];

    always_comb begin
        launch_vld_d = bus.in_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            launch_vld_q <= 1'b0;
        end else begin
            launch_vld_q <= launch_vld_d;
        end
    end

    assign vld_c[0] = launch_vld_q;
    assign acc_c[0] = '0;

`ifdef CORDIC_QUAD_EN
    logic [1:0] launch_quad_d, launch_quad_q;
    logic [1:0] quad_c [NSTAGE+1];

    always_comb begin
        launch_quad_d = bus.quad_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            launch_quad_q <= 2'd0;
        end else begin
            launch_quad_q <= launch_quad_d;
        end
    end

    assign quad_c[0] = launch_quad_q;
`endif

    for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
        localparam logic [31:0] ATAN_FULL = atan_scaled(k, ANG_W);

        cordic_acc_slot #(
            .ANG_W  (ANG_W),
            .ATAN_K (ATAN_FULL[ANG_W-1:0])
        ) u_slot (
            .clock  (clock),
            .reset  (reset),
            .vld_i  (vld_c[k]),
            .acc_i  (acc_c[k]),
            .cmp_i  (bus.cmp_bits[k]),
`ifdef CORDIC_QUAD_EN
            .quad_i (quad_c[k]),
            .quad_o (quad_c[k+1]),
`endif
            .vld_o  (vld_c[k+1]),
            .acc_o  (acc_c[k+1])
        );
    end

    logic             out_valid_d, out_valid_q;
    logic [ANG_W-1:0] out_angle_d, out_angle_q;

    always_comb begin
        out_valid_d = vld_c[NSTAGE];
        out_angle_d = out_angle_q;
        if (vld_c[NSTAGE]) begin
`ifdef CORDIC_QUAD_EN
            out_angle_d = acc_c[NSTAGE]
                        + {quad_c[NSTAGE], {(ANG_W-QUAD_SHIFT_FROM_MSB){1'b0}}};
`else
            out_angle_d = acc_c[NSTAGE];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_angle_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_angle_q <= out_angle_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_angle = out_angle_q;

endmodule
